// File: rtl/servant_rst_seq_pkg.sv
// Shared state encodings and reset-cause codes for the servant reset sequencer.
package servant_rst_seq_pkg;

  typedef logic [1:0] state_t;
  typedef logic [1:0] cause_t;

  localparam state_t ST_WAIT_LOCK = 2'd0;
  localparam state_t ST_HOLD      = 2'd1;
  localparam state_t ST_RELEASE   = 2'd2;
  localparam state_t ST_RUN       = 2'd3;

  localparam cause_t CAUSE_POR  = 2'd0;
  localparam cause_t CAUSE_LOCK = 2'd1;
  localparam cause_t CAUSE_SW   = 2'd2;

endpackage

// File: rtl/servant_rst_sync.sv
// Multi-flop synchroniser bringing the asynchronous PLL lock into the system clock domain.
module servant_rst_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/servant_rst_seq.sv
// Reset sequencer: qualifies PLL lock, stretches reset, then releases the reset
// domains one after another in thermometer order and records why it last reset.
module servant_rst_seq
  import servant_rst_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_FILTER = 3,
  parameter int unsigned RST_CYCLES  = 16,
  parameter int unsigned NUM_DOMAINS = 2,
  parameter int unsigned STAGGER     = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_pll_locked,
  input  logic                   i_sw_rst,
  output logic [NUM_DOMAINS-1:0] o_rst,
  output logic                   o_ready,
  output logic [1:0]             o_cause
);

  localparam int unsigned FILT_W = $clog2(LOCK_FILTER + 1);
  localparam int unsigned CNT_W  = $clog2(RST_CYCLES + 1);
  localparam int unsigned STG_W  = $clog2(STAGGER + 1);
  localparam int unsigned IDX_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [FILT_W-1:0] FILT_LAST  = FILT_W'(LOCK_FILTER - 1);
  localparam logic [FILT_W-1:0] FILT_MAX   = FILT_W'(LOCK_FILTER);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(RST_CYCLES);
  localparam logic [STG_W-1:0]  STG_LAST   = STG_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX    = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [IDX_W-1:0]  IDX_PENULT = IDX_W'(NUM_DOMAINS - 2);

  logic lock_s;

  state_t                 state_q, state_d;
  logic [FILT_W-1:0]      filt_q, filt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [STG_W-1:0]       stg_q, stg_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   ready_q, ready_d;
  cause_t                 cause_q, cause_d;

  servant_rst_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (i_clk),
    .rst_ni(i_rst_n),
    .d_i   (i_pll_locked),
    .q_o   (lock_s)
  );

  // Lock loss overrides everything once past the lock wait; a shift left by one
  // clears the next domain, so o_rst can only fall in thermometer order.
  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    cnt_d   = cnt_q;
    stg_d   = stg_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    cause_d = cause_q;

    if (state_q != ST_WAIT_LOCK && !lock_s) begin
      rst_d   = '1;
      ready_d = 1'b0;
      filt_d  = '0;
      state_d = ST_WAIT_LOCK;
      if (state_q == ST_RUN) begin
        cause_d = CAUSE_LOCK;
      end
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          if (!lock_s) begin
            filt_d = '0;
          end else if (filt_q >= FILT_LAST) begin
            filt_d  = FILT_MAX;
            cnt_d   = '0;
            state_d = ST_HOLD;
          end else begin
            filt_d = filt_q + FILT_W'(1);
          end
        end
        ST_HOLD: begin
          if (cnt_q >= CNT_LAST) begin
            cnt_d = CNT_MAX;
            rst_d = rst_q << 1;
            idx_d = '0;
            stg_d = '0;
            if (NUM_DOMAINS == 1) begin
              ready_d = 1'b1;
              state_d = ST_RUN;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (stg_q >= STG_LAST) begin
            stg_d = '0;
            rst_d = rst_q << 1;
            if (idx_q != IDX_MAX) begin
              idx_d = idx_q + IDX_W'(1);
            end
            if (idx_q == IDX_PENULT) begin
              ready_d = 1'b1;
              state_d = ST_RUN;
            end
          end else begin
            stg_d = stg_q + STG_W'(1);
          end
        end
        ST_RUN: begin
          if (i_sw_rst) begin
            rst_d   = '1;
            ready_d = 1'b0;
            cause_d = CAUSE_SW;
            cnt_d   = '0;
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d = ST_WAIT_LOCK;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_WAIT_LOCK;
      filt_q  <= '0;
      cnt_q   <= '0;
      stg_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      cause_q <= CAUSE_POR;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
      stg_q   <= stg_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      cause_q <= cause_d;
    end
  end

  assign o_rst   = rst_q;
  assign o_ready = ready_q;
  assign o_cause = cause_q;

endmodule

// File: tb/tb_servant_rst_seq.sv
// Bench for servant_rst_seq: a timed vector table and hand sequences for the corner
// cases, then random lock/software-reset traffic against a timing-based reference model.
module tb_servant_rst_seq;

  localparam int SYNC = 2;
  localparam int LF   = 3;
  localparam int RSTC = 16;

  logic       clk = 1'b0;
  logic       rstN;
  logic       lock;
  logic       sw;
  logic [1:0] rst0;
  logic       rdy0;
  logic [1:0] cause0;
  logic [0:0] rst1;
  logic       rdy1;
  logic [1:0] cause1;

  int checks  = 0;
  int errors  = 0;
  int edgeCnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  servant_rst_seq #(
    .SYNC_STAGES(SYNC), .LOCK_FILTER(LF), .RST_CYCLES(RSTC), .NUM_DOMAINS(2), .STAGGER(4)
  ) u_dut0 (
    .i_clk(clk), .i_rst_n(rstN), .i_pll_locked(lock), .i_sw_rst(sw),
    .o_rst(rst0), .o_ready(rdy0), .o_cause(cause0)
  );

  servant_rst_seq #(
    .SYNC_STAGES(SYNC), .LOCK_FILTER(LF), .RST_CYCLES(RSTC), .NUM_DOMAINS(1), .STAGGER(1)
  ) u_dut1 (
    .i_clk(clk), .i_rst_n(rstN), .i_pll_locked(lock), .i_sw_rst(sw),
    .o_rst(rst1), .o_ready(rdy1), .o_cause(cause1)
  );

  // Reference model: tracks time since the reset-hold phase started; domain k is
  // released once that time reaches RSTC + stagger*k.
  int         mNd[2]  = '{2, 1};
  int         mStg[2] = '{4, 1};
  bit         mWait[2];
  int         mGood[2];
  int         mT[2];
  logic [1:0] mCause[2];
  logic       mSync[SYNC];

  task automatic modelStep(input int m, input logic lockS);
    bit running;
    running = !mWait[m] && (mT[m] >= RSTC + mStg[m] * (mNd[m] - 1));
    if (mWait[m]) begin
      if (lockS) begin
        mGood[m]++;
        if (mGood[m] >= LF) begin
          mWait[m] = 1'b0;
          mT[m]    = 0;
        end
      end else begin
        mGood[m] = 0;
      end
    end else if (!lockS) begin
      if (running) mCause[m] = 2'd1;
      mWait[m] = 1'b1;
      mGood[m] = 0;
    end else if (running && sw) begin
      mT[m]     = 0;
      mCause[m] = 2'd2;
    end else if (mT[m] < 100000) begin
      mT[m]++;
    end
  endtask

  function automatic logic [1:0] modelRst(input int m);
    logic [1:0] r;
    r = '0;
    for (int k = 0; k < mNd[m]; k++) r[k] = mWait[m] || (mT[m] < RSTC + mStg[m] * k);
    return r;
  endfunction

  function automatic logic modelRdy(input int m);
    return !mWait[m] && (mT[m] >= RSTC + mStg[m] * (mNd[m] - 1));
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rstN);
      if (!rstN) begin
        for (int m = 0; m < 2; m++) begin
          mWait[m]  = 1'b1;
          mGood[m]  = 0;
          mT[m]     = 0;
          mCause[m] = 2'd0;
        end
        for (int i = 0; i < SYNC; i++) mSync[i] = 1'b0;
      end else begin
        for (int m = 0; m < 2; m++) modelStep(m, mSync[SYNC-1]);
        for (int i = SYNC - 1; i > 0; i--) mSync[i] = mSync[i-1];
        mSync[0] = lock;
      end
    end
  end

  typedef struct {
    logic       lock;
    logic       sw;
    int         edgeNo;
    logic [1:0] expRst;
    logic       expRdy;
    logic [1:0] expCause;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic l, input logic s, input int e,
                        input logic [1:0] r, input logic rd, input logic [1:0] c);
    vec_t v;
    v.lock = l; v.sw = s; v.edgeNo = e; v.expRst = r; v.expRdy = rd; v.expCause = c;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic l, input logic s);
    lock = l;
    sw   = s;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edgeCnt);
    end
  endtask

  task automatic waitEdge(input int target);
    while (edgeCnt < target) @(negedge clk);
  endtask

  function automatic logic [7:0] pack0(input logic [1:0] r, input logic rd, input logic [1:0] c);
    return {3'b000, r, rd, c};
  endfunction

  function automatic logic [7:0] pack1(input logic r, input logic rd, input logic [1:0] c);
    return {4'b0000, r, rd, c};
  endfunction

  int         base;
  int         lowLeft;
  logic [1:0] expR0;
  logic [1:0] expR1;

  initial begin
    rstN = 1'b1;
    applyStimulus(1'b1, 1'b0);
    #1 rstN = 1'b0;
    #1;
    checkOutput("por_reset_dut0", pack0(rst0, rdy0, cause0), pack0(2'b11, 1'b0, 2'd0));
    checkOutput("por_reset_dut1", pack1(rst1[0], rdy1, cause1), pack1(1'b1, 1'b0, 2'd0));
    #1 rstN = 1'b1;

    // POR release, lock loss in RUN, sw reset, then lock loss coinciding with sw request.
    addVec(1, 0,  20, 2'b11, 0, 2'd0);
    addVec(1, 0,  21, 2'b10, 0, 2'd0);
    addVec(1, 0,  24, 2'b10, 0, 2'd0);
    addVec(1, 0,  25, 2'b00, 1, 2'd0);
    addVec(1, 0,  30, 2'b00, 1, 2'd0);
    addVec(0, 0,  32, 2'b00, 1, 2'd0);
    addVec(0, 0,  33, 2'b11, 0, 2'd1);
    addVec(0, 0,  35, 2'b11, 0, 2'd1);
    addVec(1, 0,  55, 2'b11, 0, 2'd1);
    addVec(1, 0,  56, 2'b10, 0, 2'd1);
    addVec(1, 0,  59, 2'b10, 0, 2'd1);
    addVec(1, 0,  60, 2'b00, 1, 2'd1);
    addVec(1, 0,  62, 2'b00, 1, 2'd1);
    addVec(1, 1,  63, 2'b11, 0, 2'd2);
    addVec(1, 0,  64, 2'b11, 0, 2'd2);
    addVec(1, 0,  78, 2'b11, 0, 2'd2);
    addVec(1, 0,  79, 2'b10, 0, 2'd2);
    addVec(1, 0,  82, 2'b10, 0, 2'd2);
    addVec(1, 0,  83, 2'b00, 1, 2'd2);
    addVec(1, 0,  85, 2'b00, 1, 2'd2);
    addVec(0, 0,  87, 2'b00, 1, 2'd2);
    addVec(0, 1,  88, 2'b11, 0, 2'd1);
    addVec(0, 0,  90, 2'b11, 0, 2'd1);
    addVec(1, 0, 110, 2'b11, 0, 2'd1);
    addVec(1, 0, 111, 2'b10, 0, 2'd1);
    addVec(1, 0, 115, 2'b00, 1, 2'd1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].lock, vecs[i].sw);
      waitEdge(vecs[i].edgeNo);
      checkOutput($sformatf("table%0d_dut0", i), pack0(rst0, rdy0, cause0),
                  pack0(vecs[i].expRst, vecs[i].expRdy, vecs[i].expCause));
      checkOutput($sformatf("table%0d_dut1", i), pack1(rst1[0], rdy1, cause1),
                  pack1(vecs[i].expRst[0], ~vecs[i].expRst[0], vecs[i].expCause));
    end

    // One-cycle lock glitch after two good samples delays release by three edges.
    applyStimulus(1'b1, 1'b0);
    rstN = 1'b0;
    #1;
    checkOutput("async_rst_run", pack0(rst0, rdy0, cause0), pack0(2'b11, 1'b0, 2'd0));
    #1 rstN = 1'b1;
    base = edgeCnt;
    waitEdge(base + 2);
    applyStimulus(1'b0, 1'b0);
    waitEdge(base + 3);
    applyStimulus(1'b1, 1'b0);
    waitEdge(base + 23);
    checkOutput("glitch_hold_dut0", pack0(rst0, rdy0, cause0), pack0(2'b11, 1'b0, 2'd0));
    checkOutput("glitch_hold_dut1", pack1(rst1[0], rdy1, cause1), pack1(1'b1, 1'b0, 2'd0));
    waitEdge(base + 24);
    checkOutput("glitch_rel_dut0", pack0(rst0, rdy0, cause0), pack0(2'b10, 1'b0, 2'd0));
    checkOutput("glitch_rel_dut1", pack1(rst1[0], rdy1, cause1), pack1(1'b0, 1'b1, 2'd0));
    waitEdge(base + 26);
    checkOutput("mid_release", pack0(rst0, rdy0, cause0), pack0(2'b10, 1'b0, 2'd0));

    // Async reset between clock edges while domains are still being released.
    #2 rstN = 1'b0;
    #1;
    checkOutput("async_rst_release_dut0", pack0(rst0, rdy0, cause0), pack0(2'b11, 1'b0, 2'd0));
    checkOutput("async_rst_release_dut1", pack1(rst1[0], rdy1, cause1), pack1(1'b1, 1'b0, 2'd0));
    #1 rstN = 1'b1;

    lowLeft = 0;
    repeat (4000) begin
      @(negedge clk);
      expR0 = modelRst(0);
      expR1 = modelRst(1);
      checkOutput("rand_dut0", pack0(rst0, rdy0, cause0), pack0(expR0, modelRdy(0), mCause[0]));
      checkOutput("rand_dut1", pack1(rst1[0], rdy1, cause1), pack1(expR1[0], modelRdy(1), mCause[1]));
      if (lowLeft > 0) begin
        lock = ($urandom_range(0, 3) == 0);
        lowLeft--;
      end else begin
        lock = 1'b1;
        if ($urandom_range(0, 79) == 0) lowLeft = $urandom_range(1, 8);
      end
      sw = ($urandom_range(0, 24) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
